eflags_wb: RTL

Writeback-stage EFLAGS unit for the execute/writeback boundary. It consumes ALU1 results from execute: the ALU1 flag vector, the CMPS flag vector, per-flag load enables, and the DF value. It buffers these results for one pipeline stage with a valid/ready handshake, then commits them into the architectural EFLAGS register. It feeds bypassed CF/AF/DF back to ALU1's `CF_in`/`AF_in`/`DF_in` and holds a one-deep interrupt shadow copy of EFLAGS for ISR entry and IRET.

---
 rtl/eflags_wb_if.sv | 35 +++
 rtl/eflags_wb.sv | 100 ++++++++++
 2 files changed

// File: rtl/eflags_wb_if.sv
// Execute-to-writeback EFLAGS bus: flag updates, ISR/IRET/POPF controls and
// the committed/bypassed flag outputs.
interface eflags_wb_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [5:0]  alu1_flags;
  logic [5:0]  cmps_flags;
  logic        sel_cmps;
  logic [5:0]  ld_flags;
  logic        ld_df;
  logic        df_val_ex;
  logic        wb_stall;
  logic        isr_entry;
  logic        iret;
  logic        popf;
  logic [31:0] popf_data;
  logic [31:0] eflags;
  logic        CF_fwd;
  logic        AF_fwd;
  logic        DF_fwd;
  logic        shadow_full;
  logic        nest_err;

  modport master (
    output ex_valid, alu1_flags, cmps_flags, sel_cmps, ld_flags, ld_df, df_val_ex,
           wb_stall, isr_entry, iret, popf, popf_data,
    input  ex_ready, eflags, CF_fwd, AF_fwd, DF_fwd, shadow_full, nest_err
  );

  modport slave (
    input  ex_valid, alu1_flags, cmps_flags, sel_cmps, ld_flags, ld_df, df_val_ex,
           wb_stall, isr_entry, iret, popf, popf_data,
    output ex_ready, eflags, CF_fwd, AF_fwd, DF_fwd, shadow_full, nest_err
  );
endinterface

// File: rtl/eflags_wb.sv
// Writeback-stage EFLAGS: one-entry pending buffer, architectural commit,
// CF/AF/DF bypass to ALU1 and a one-deep interrupt shadow copy.
module eflags_wb (
   input logic clk,
   input logic rst,
   eflags_wb_if.slave bus
);
   typedef enum logic {SH_EMPTY, SH_FULL} sh_state_t;

   // Writable flag positions: CF PF AF ZF SF DF OF
   localparam logic [31:0] FLAG_MASK = 32'h0000_0CD5;
   localparam logic [31:0] FIXED_ONE = 32'h0000_0002;

   logic        wb_valid;
   logic [5:0]  pend_src;
   logic [5:0]  pend_ld;
   logic        pend_ld_df;
   logic        pend_df;
   logic [31:0] eflags_q;
   logic [31:0] shadow_q;
   logic [31:0] commit_val;
   sh_state_t   state;
   logic        shadow_full_q;
   logic        nest_err_q;
   logic        accept;
   logic        commit;

   assign bus.ex_ready = ~wb_valid | ~bus.wb_stall;
   assign accept       = bus.ex_valid & bus.ex_ready;
   assign commit       = wb_valid & ~bus.wb_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid   <= 1'b0;
         pend_src   <= '0;
         pend_ld    <= '0;
         pend_ld_df <= 1'b0;
         pend_df    <= 1'b0;
      end else if (accept) begin
         wb_valid   <= 1'b1;
         pend_src   <= bus.sel_cmps ? bus.cmps_flags : bus.alu1_flags;
         pend_ld    <= bus.ld_flags;
         pend_ld_df <= bus.ld_df;
         pend_df    <= bus.df_val_ex;
      end else if (commit) begin
         wb_valid   <= 1'b0;
      end
   end

   // EFLAGS as it stands after this cycle's commit; also the ISR save value
   always_comb begin
      commit_val = eflags_q;
      if (commit) begin
         if (pend_ld[0]) commit_val[0]  = pend_src[0];
         if (pend_ld[1]) commit_val[2]  = pend_src[1];
         if (pend_ld[2]) commit_val[4]  = pend_src[2];
         if (pend_ld[3]) commit_val[6]  = pend_src[3];
         if (pend_ld[4]) commit_val[7]  = pend_src[4];
         if (pend_ld[5]) commit_val[11] = pend_src[5];
         if (pend_ld_df) commit_val[10] = pend_df;
      end
   end

   // iret wins over everything, including a stray isr_entry or popf
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         eflags_q      <= FIXED_ONE;
         shadow_q      <= '0;
         state         <= SH_EMPTY;
         shadow_full_q <= 1'b0;
         nest_err_q    <= 1'b0;
      end else if (bus.iret) begin
         if (state == SH_FULL) begin
            eflags_q      <= shadow_q;
            state         <= SH_EMPTY;
            shadow_full_q <= 1'b0;
         end else begin
            nest_err_q    <= 1'b1;
         end
      end else begin
         eflags_q <= bus.popf ? ((bus.popf_data & FLAG_MASK) | FIXED_ONE) : commit_val;
         if (bus.isr_entry) begin
            if (state == SH_EMPTY) begin
               shadow_q      <= commit_val;
               state         <= SH_FULL;
               shadow_full_q <= 1'b1;
            end else begin
               nest_err_q    <= 1'b1;
            end
         end
      end
   end

   assign bus.eflags      = eflags_q;
   assign bus.shadow_full = shadow_full_q;
   assign bus.nest_err    = nest_err_q;
   assign bus.CF_fwd      = (wb_valid & pend_ld[0]) ? pend_src[0] : eflags_q[0];
   assign bus.AF_fwd      = (wb_valid & pend_ld[2]) ? pend_src[2] : eflags_q[4];
   assign bus.DF_fwd      = (wb_valid & pend_ld_df) ? pend_df    : eflags_q[10];
endmodule
